// File: rtl/pipe_pkg.sv
// Shared definitions for the dual-issue MEM stage: access FSM encoding,
// MemtoReg load encoding and the link register index.
package pipe_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC1 = 2'd1;
    localparam logic [1:0] ST_ACC2 = 2'd2;

    localparam logic [1:0] MTR_LOAD = 2'b11;

    localparam logic [4:0] LINK_REG = 5'd31;

    // A lane touches data memory when it stores or selects the load result.
    function automatic logic is_mem_op(input logic mem_write, input logic [1:0] mtr_lo);
        return mem_write | (mtr_lo == MTR_LOAD);
    endfunction

    function automatic logic is_load(input logic [1:0] mtr_lo);
        return (mtr_lo == MTR_LOAD);
    endfunction

endpackage

// File: rtl/dmem_port_seq.sv
// Serialises the two lane accesses onto the single data-memory port, lane 1 first.
// MEMSTAGE_ST_LD_FWD_EN: a lane-1 store feeding a same-address lane-2 load skips the second access.
module dmem_port_seq
    import pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          go1,
    input  logic          go2,
    input  logic          we1,
    input  logic          ld1,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          we2,
    input  logic          ld2,
    input  logic [DW-1:0] addr2,
    input  logic [DW-1:0] wdata2,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ready,
    input  logic [DW-1:0] dmem_rdata,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [1:0]    state
);

    // Handshake: a lane access is held (req/we/addr/wdata stable) from entry into
    // its ACC state until the cycle dmem_ready is high; that cycle completes it.

    logic [1:0] state_nxt;
    logic       mem2;
    logic       fwd_hit;
    logic       done1;
    logic       done2;

    assign mem2  = we2 | ld2;
    assign done1 = (state == ST_ACC1) && dmem_ready;
    assign done2 = (state == ST_ACC2) && dmem_ready;

`ifdef MEMSTAGE_ST_LD_FWD_EN
    assign fwd_hit = we1 && ld2 && (addr1 == addr2);
`else
    assign fwd_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    if (go1)      state_nxt = ST_ACC1;
                    else if (go2) state_nxt = ST_ACC2;
                    else          state_nxt = ST_IDLE;
                end
            end
            ST_ACC1: begin
                if (dmem_ready) begin
                    if (fwd_hit)   state_nxt = ST_IDLE;
                    else if (mem2) state_nxt = ST_ACC2;
                    else           state_nxt = ST_IDLE;
                end
            end
            ST_ACC2: begin
                if (dmem_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        case (state)
            ST_ACC1: begin
                dmem_req   = 1'b1;
                dmem_we    = we1;
                dmem_addr  = addr1;
                dmem_wdata = wdata1;
            end
            ST_ACC2: begin
                dmem_req   = 1'b1;
                dmem_we    = we2;
                dmem_addr  = addr2;
                dmem_wdata = wdata2;
            end
            default: begin
                dmem_req = 1'b0;
            end
        endcase
    end

    // Read data holds its last captured value; stores and ALU ops leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (done1 && ld1) begin
                rdata1 <= dmem_rdata;
            end
            if (done1 && fwd_hit) begin
                rdata2 <= wdata1;
            end else if (done2 && ld2) begin
                rdata2 <= dmem_rdata;
            end
        end
    end

endmodule

// File: rtl/memory_stage_dual.sv
// Dual-issue MEM stage: E->M bundle register, writeback masking while the
// shared data-memory port is busy. Optional macro: MEMSTAGE_ST_LD_FWD_EN.
module memory_stage_dual
    import pipe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int MTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallM,
    input  logic             flushM,
    input  logic [MTR_W-1:0] MemtoRegE1,
    input  logic [MTR_W-1:0] MemtoRegE2,
    input  logic             RegWriteE1,
    input  logic             RegWriteE2,
    input  logic             MemWriteE1,
    input  logic             MemWriteE2,
    input  logic             jumpE1,
    input  logic             jumpE2,
    input  logic [DW-1:0]    aluoutE1,
    input  logic [DW-1:0]    aluoutE2,
    input  logic [DW-1:0]    WriteDataE1,
    input  logic [DW-1:0]    WriteDataE2,
    input  logic [RW-1:0]    writeregE1,
    input  logic [RW-1:0]    writeregE2,
    input  logic [DW-1:0]    PCPlus8E,
    output logic [MTR_W-1:0] MemtoRegM1,
    output logic [MTR_W-1:0] MemtoRegM2,
    output logic             RegWriteM1,
    output logic             RegWriteM2,
    output logic             jumpM1,
    output logic             jumpM2,
    output logic [DW-1:0]    ReadDataM1,
    output logic [DW-1:0]    ReadDataM2,
    output logic [DW-1:0]    aluoutM1,
    output logic [DW-1:0]    aluoutM2,
    output logic [DW-1:0]    PCPlus8M,
    output logic [RW-1:0]    writeregM1,
    output logic [RW-1:0]    writeregM2,
    output logic             memBusyM,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DW-1:0]    dmem_addr,
    output logic [DW-1:0]    dmem_wdata,
    input  logic             dmem_ready,
    input  logic [DW-1:0]    dmem_rdata
);

    logic [1:0]    state;
    logic          load_bundle;
    logic          go1;
    logic          go2;
    logic          rw1_q;
    logic          rw2_q;
    logic          mw1_q;
    logic          mw2_q;
    logic [DW-1:0] wd1_q;
    logic [DW-1:0] wd2_q;

    assign memBusyM    = (state != ST_IDLE);
    assign load_bundle = !stallM && (state == ST_IDLE);

    // A flushed bundle is all zeros, so it never starts an access.
    assign go1 = !flushM && is_mem_op(MemWriteE1, MemtoRegE1[1:0]);
    assign go2 = !flushM && is_mem_op(MemWriteE2, MemtoRegE2[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            MemtoRegM1 <= '0;
            MemtoRegM2 <= '0;
            rw1_q      <= 1'b0;
            rw2_q      <= 1'b0;
            mw1_q      <= 1'b0;
            mw2_q      <= 1'b0;
            jumpM1     <= 1'b0;
            jumpM2     <= 1'b0;
            aluoutM1   <= '0;
            aluoutM2   <= '0;
            wd1_q      <= '0;
            wd2_q      <= '0;
            writeregM1 <= '0;
            writeregM2 <= '0;
            PCPlus8M   <= '0;
        end else if (load_bundle) begin
            if (flushM) begin
                MemtoRegM1 <= '0;
                MemtoRegM2 <= '0;
                rw1_q      <= 1'b0;
                rw2_q      <= 1'b0;
                mw1_q      <= 1'b0;
                mw2_q      <= 1'b0;
                jumpM1     <= 1'b0;
                jumpM2     <= 1'b0;
                aluoutM1   <= '0;
                aluoutM2   <= '0;
                wd1_q      <= '0;
                wd2_q      <= '0;
                writeregM1 <= '0;
                writeregM2 <= '0;
                PCPlus8M   <= '0;
            end else begin
                MemtoRegM1 <= MemtoRegE1;
                MemtoRegM2 <= MemtoRegE2;
                rw1_q      <= RegWriteE1;
                rw2_q      <= RegWriteE2;
                mw1_q      <= MemWriteE1;
                mw2_q      <= MemWriteE2;
                jumpM1     <= jumpE1;
                jumpM2     <= jumpE2;
                aluoutM1   <= aluoutE1;
                aluoutM2   <= aluoutE2;
                wd1_q      <= WriteDataE1;
                wd2_q      <= WriteDataE2;
                writeregM1 <= writeregE1;
                writeregM2 <= writeregE2;
                PCPlus8M   <= PCPlus8E;
            end
        end
    end

    // Writeback sees bubbles while busy and the real bundle in the first idle cycle.
    assign RegWriteM1 = rw1_q && !memBusyM;
    assign RegWriteM2 = rw2_q && !memBusyM;

    dmem_port_seq #(
        .DW(DW)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .load       (load_bundle),
        .go1        (go1),
        .go2        (go2),
        .we1        (mw1_q),
        .ld1        (is_load(MemtoRegM1[1:0])),
        .addr1      (aluoutM1),
        .wdata1     (wd1_q),
        .we2        (mw2_q),
        .ld2        (is_load(MemtoRegM2[1:0])),
        .addr2      (aluoutM2),
        .wdata2     (wd2_q),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .rdata1     (ReadDataM1),
        .rdata2     (ReadDataM2),
        .state      (state)
    );

endmodule

// File: tb/tb_memory_stage_dual.sv
// Randomised bench for memory_stage_dual with a transaction-level reference model
// and a latency-programmable memory responder.
module tb_memory_stage_dual;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int MTR_W = 4;

    localparam int OP_ALU = 0;
    localparam int OP_LD  = 1;
    localparam int OP_ST  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stallM = 1'b0;
    logic             flushM = 1'b0;
    logic [MTR_W-1:0] MemtoRegE1 = '0, MemtoRegE2 = '0;
    logic             RegWriteE1 = 1'b0, RegWriteE2 = 1'b0;
    logic             MemWriteE1 = 1'b0, MemWriteE2 = 1'b0;
    logic             jumpE1 = 1'b0, jumpE2 = 1'b0;
    logic [DW-1:0]    aluoutE1 = '0, aluoutE2 = '0;
    logic [DW-1:0]    WriteDataE1 = '0, WriteDataE2 = '0;
    logic [RW-1:0]    writeregE1 = '0, writeregE2 = '0;
    logic [DW-1:0]    PCPlus8E = '0;

    logic [MTR_W-1:0] MemtoRegM1, MemtoRegM2;
    logic             RegWriteM1, RegWriteM2;
    logic             jumpM1, jumpM2;
    logic [DW-1:0]    ReadDataM1, ReadDataM2;
    logic [DW-1:0]    aluoutM1, aluoutM2;
    logic [DW-1:0]    PCPlus8M;
    logic [RW-1:0]    writeregM1, writeregM2;
    logic             memBusyM;
    logic             dmem_req, dmem_we;
    logic [DW-1:0]    dmem_addr, dmem_wdata;
    logic             dmem_ready;
    logic [DW-1:0]    dmem_rdata;

    memory_stage_dual #(.DW(DW), .RW(RW), .MTR_W(MTR_W)) dut (
        .clk(clk), .rst(rst), .stallM(stallM), .flushM(flushM),
        .MemtoRegE1(MemtoRegE1), .MemtoRegE2(MemtoRegE2),
        .RegWriteE1(RegWriteE1), .RegWriteE2(RegWriteE2),
        .MemWriteE1(MemWriteE1), .MemWriteE2(MemWriteE2),
        .jumpE1(jumpE1), .jumpE2(jumpE2),
        .aluoutE1(aluoutE1), .aluoutE2(aluoutE2),
        .WriteDataE1(WriteDataE1), .WriteDataE2(WriteDataE2),
        .writeregE1(writeregE1), .writeregE2(writeregE2),
        .PCPlus8E(PCPlus8E),
        .MemtoRegM1(MemtoRegM1), .MemtoRegM2(MemtoRegM2),
        .RegWriteM1(RegWriteM1), .RegWriteM2(RegWriteM2),
        .jumpM1(jumpM1), .jumpM2(jumpM2),
        .ReadDataM1(ReadDataM1), .ReadDataM2(ReadDataM2),
        .aluoutM1(aluoutM1), .aluoutM2(aluoutM2),
        .PCPlus8M(PCPlus8M),
        .writeregM1(writeregM1), .writeregM2(writeregM2),
        .memBusyM(memBusyM),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    logic [DW-1:0] mem [logic [DW-1:0]];
    logic [DW-1:0] ref_mem [logic [DW-1:0]];
    logic          resp_auto = 1'b1;
    logic          auto_ready = 1'b0;
    logic [DW-1:0] auto_rdata = '0;
    logic          man_ready = 1'b0;
    logic [DW-1:0] man_rdata = '0;
    int            lat_q[$];
    logic [DW-1:0] acc_addr_q[$];
    logic [DW-1:0] acc_we_q[$];
    logic [DW-1:0] acc_wd_q[$];
    bit            have_lat = 1'b0;
    int            cur_lat = 0;
    int            wait_cnt = 0;

    assign dmem_ready = resp_auto ? auto_ready : man_ready;
    assign dmem_rdata = resp_auto ? auto_rdata : man_rdata;

    function automatic logic [DW-1:0] init_word(input logic [DW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(negedge clk) begin
        if (!resp_auto || rst || !dmem_req) begin
            auto_ready = 1'b0;
            have_lat   = 1'b0;
        end else begin
            if (!have_lat) begin
                cur_lat  = 0;
                if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
                wait_cnt = 0;
                have_lat = 1'b1;
            end
            if (wait_cnt >= cur_lat) begin
                auto_ready = 1'b1;
                auto_rdata = mem.exists(dmem_addr) ? mem[dmem_addr] : init_word(dmem_addr);
                acc_addr_q.push_back(dmem_addr);
                acc_we_q.push_back({31'b0, dmem_we});
                acc_wd_q.push_back(dmem_wdata);
                if (dmem_we) mem[dmem_addr] = dmem_wdata;
                have_lat = 1'b0;
            end else begin
                auto_ready = 1'b0;
                wait_cnt++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int force_lat = -1;

    logic [DW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_we_q[$];
    logic [DW-1:0] exp_wd_q[$];

    logic [MTR_W-1:0] exp_mtr1 = '0, exp_mtr2 = '0;
    logic             exp_rw1 = 1'b0, exp_rw2 = 1'b0;
    logic             exp_j1 = 1'b0, exp_j2 = 1'b0;
    logic [DW-1:0]    exp_alu1 = '0, exp_alu2 = '0, exp_pc8 = '0;
    logic [RW-1:0]    exp_wr1 = '0, exp_wr2 = '0;
    logic [DW-1:0]    exp_rd1 = '0, exp_rd2 = '0;
    int               exp_busy = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [DW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic int pick_lat();
        return (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
    endfunction

    task automatic push_access(input logic [DW-1:0] a, input logic we, input logic [DW-1:0] wd);
        int l;
        l = pick_lat();
        lat_q.push_back(l);
        exp_busy += l + 1;
        exp_addr_q.push_back(a);
        exp_we_q.push_back({31'b0, we});
        exp_wd_q.push_back(wd);
    endtask

    // Transaction-level model: what one bundle must do to memory and writeback.
    task automatic model_bundle(input logic flush);
        logic ld1, ld2, st1, st2, fwd;
        exp_busy = 0;
        if (flush) begin
            exp_mtr1 = '0; exp_mtr2 = '0; exp_rw1 = 0; exp_rw2 = 0;
            exp_j1 = 0; exp_j2 = 0; exp_alu1 = '0; exp_alu2 = '0;
            exp_pc8 = '0; exp_wr1 = '0; exp_wr2 = '0;
            return;
        end
        exp_mtr1 = MemtoRegE1; exp_mtr2 = MemtoRegE2;
        exp_rw1 = RegWriteE1; exp_rw2 = RegWriteE2;
        exp_j1 = jumpE1; exp_j2 = jumpE2;
        exp_alu1 = aluoutE1; exp_alu2 = aluoutE2;
        exp_pc8 = PCPlus8E; exp_wr1 = writeregE1; exp_wr2 = writeregE2;
        ld1 = (MemtoRegE1[1:0] == 2'b11); st1 = MemWriteE1;
        ld2 = (MemtoRegE2[1:0] == 2'b11); st2 = MemWriteE2;
        fwd = 1'b0;
`ifdef MEMSTAGE_ST_LD_FWD_EN
        fwd = st1 && ld2 && (aluoutE1 == aluoutE2);
`endif
        if (ld1 || st1) begin
            push_access(aluoutE1, st1, WriteDataE1);
            if (ld1) exp_rd1 = ref_rd(aluoutE1);
            if (st1) ref_mem[aluoutE1] = WriteDataE1;
        end
        if (fwd) begin
            exp_rd2 = WriteDataE1;
        end else if (ld2 || st2) begin
            push_access(aluoutE2, st2, WriteDataE2);
            if (ld2) exp_rd2 = ref_rd(aluoutE2);
            if (st2) ref_mem[aluoutE2] = WriteDataE2;
        end
    endtask

    task automatic check_outputs(input string pfx);
        check_val({pfx, ".mtr1"}, {28'b0, MemtoRegM1}, {28'b0, exp_mtr1});
        check_val({pfx, ".mtr2"}, {28'b0, MemtoRegM2}, {28'b0, exp_mtr2});
        check_val({pfx, ".rw1"}, {31'b0, RegWriteM1}, {31'b0, exp_rw1});
        check_val({pfx, ".rw2"}, {31'b0, RegWriteM2}, {31'b0, exp_rw2});
        check_val({pfx, ".jump1"}, {31'b0, jumpM1}, {31'b0, exp_j1});
        check_val({pfx, ".jump2"}, {31'b0, jumpM2}, {31'b0, exp_j2});
        check_val({pfx, ".alu1"}, aluoutM1, exp_alu1);
        check_val({pfx, ".alu2"}, aluoutM2, exp_alu2);
        check_val({pfx, ".pc8"}, PCPlus8M, exp_pc8);
        check_val({pfx, ".wr1"}, {27'b0, writeregM1}, {27'b0, exp_wr1});
        check_val({pfx, ".wr2"}, {27'b0, writeregM2}, {27'b0, exp_wr2});
        check_val({pfx, ".rd1"}, ReadDataM1, exp_rd1);
        check_val({pfx, ".rd2"}, ReadDataM2, exp_rd2);
    endtask

    task automatic check_accesses(input string pfx);
        int n;
        check_val({pfx, ".acc_count"}, acc_addr_q.size(), exp_addr_q.size());
        n = (acc_addr_q.size() < exp_addr_q.size()) ? acc_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < n; i++) begin
            check_val({pfx, ".acc_addr"}, acc_addr_q[i], exp_addr_q[i]);
            check_val({pfx, ".acc_we"}, acc_we_q[i], exp_we_q[i]);
            if (exp_we_q[i][0]) check_val({pfx, ".acc_wdata"}, acc_wd_q[i], exp_wd_q[i]);
        end
        acc_addr_q.delete(); acc_we_q.delete(); acc_wd_q.delete();
        exp_addr_q.delete(); exp_we_q.delete(); exp_wd_q.delete();
        lat_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_lane(input int lane, input int op, input logic [DW-1:0] a, input logic [DW-1:0] wd);
        logic [MTR_W-1:0] mtr;
        mtr = MTR_W'($urandom_range(0, 15));
        if (op == OP_LD) mtr[1:0] = 2'b11;
        else             mtr[1:0] = 2'($urandom_range(0, 2));
        if (lane == 1) begin
            MemtoRegE1 = mtr; MemWriteE1 = (op == OP_ST); aluoutE1 = a; WriteDataE1 = wd;
            RegWriteE1 = 1'($urandom_range(0, 1)); jumpE1 = 1'($urandom_range(0, 1));
            writeregE1 = RW'($urandom_range(0, 31));
        end else begin
            MemtoRegE2 = mtr; MemWriteE2 = (op == OP_ST); aluoutE2 = a; WriteDataE2 = wd;
            RegWriteE2 = 1'($urandom_range(0, 1)); jumpE2 = 1'($urandom_range(0, 1));
            writeregE2 = RW'($urandom_range(0, 31));
        end
        PCPlus8E = $urandom;
    endtask

    // Called at a negedge with the FSM idle; returns at the first idle negedge after.
    task automatic run_bundle(input string tag, input logic flush);
        int  busy_cnt;
        logic rw_leak;
        flushM = flush;
        stallM = 1'b0;
        model_bundle(flush);
        @(posedge clk);
        @(negedge clk);
        flushM = 1'b0;
        busy_cnt = 0;
        rw_leak = 1'b0;
        while (memBusyM && busy_cnt < 300) begin
            busy_cnt++;
            if (RegWriteM1 || RegWriteM2) rw_leak = 1'b1;
            @(negedge clk);
        end
        check_val({tag, ".busy_cycles"}, busy_cnt, exp_busy);
        check_val({tag, ".rw_masked"}, {31'b0, rw_leak}, 32'd0);
        check_outputs(tag);
        check_accesses(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset.req", {31'b0, dmem_req}, 32'd0);
        check_val("reset.busy", {31'b0, memBusyM}, 32'd0);
        check_outputs("reset");
        rst = 1'b0;

        // two ALU ops
        set_lane(1, OP_ALU, 32'h10, $urandom); set_lane(2, OP_ALU, 32'h20, $urandom);
        RegWriteE1 = 1'b1; RegWriteE2 = 1'b1;
        run_bundle("alu2", 1'b0);

        // lane-1 load with ready on the third request cycle
        mem[32'h100] = 32'hDEAD_BEEF; ref_mem[32'h100] = 32'hDEAD_BEEF;
        force_lat = 2;
        set_lane(1, OP_LD, 32'h100, $urandom); set_lane(2, OP_ALU, 32'h4, $urandom);
        RegWriteE1 = 1'b1;
        run_bundle("ld_slow", 1'b0);
        check_val("ld_slow.value", ReadDataM1, 32'hDEAD_BEEF);

        // store then load to the same address
        force_lat = 0;
        set_lane(1, OP_ST, 32'h40, 32'h55); set_lane(2, OP_LD, 32'h40, $urandom);
        run_bundle("st_ld", 1'b0);
        check_val("st_ld.value", ReadDataM2, 32'h55);

        // both lanes loading
        set_lane(1, OP_LD, 32'h8, $urandom); set_lane(2, OP_LD, 32'hC, $urandom);
        run_bundle("ld_ld", 1'b0);
        force_lat = -1;

        // stall holds the M bundle
        set_lane(1, OP_ALU, 32'h1234, $urandom); set_lane(2, OP_ALU, 32'h5678, $urandom);
        stallM = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_val("stall.alu1_held", aluoutM1, exp_alu1);
            check_val("stall.wr2_held", {27'b0, writeregM2}, {27'b0, exp_wr2});
        end
        run_bundle("stall_release", 1'b0);

        // reset in the middle of a lane-1 access, then a stray ready
        resp_auto = 1'b0;
        set_lane(1, OP_LD, 32'h100, $urandom); set_lane(2, OP_ALU, 32'h0, $urandom);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_mid.req_before", {31'b0, dmem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1; stallM = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_mtr1 = '0; exp_mtr2 = '0; exp_rw1 = 0; exp_rw2 = 0; exp_j1 = 0; exp_j2 = 0;
        exp_alu1 = '0; exp_alu2 = '0; exp_pc8 = '0; exp_wr1 = '0; exp_wr2 = '0;
        exp_rd1 = '0; exp_rd2 = '0;
        check_val("rst_mid.req", {31'b0, dmem_req}, 32'd0);
        check_val("rst_mid.busy", {31'b0, memBusyM}, 32'd0);
        check_val("rst_mid.addr", dmem_addr, 32'd0);
        check_outputs("rst_mid");
        man_ready = 1'b1; man_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
        man_ready = 1'b0;
        check_val("rst_mid.late_ready_rd1", ReadDataM1, 32'd0);
        check_val("rst_mid.late_ready_busy", {31'b0, memBusyM}, 32'd0);
        resp_auto = 1'b1;

        // randomised bundles
        for (int t = 0; t < 150; t++) begin
            logic [DW-1:0] addrs [4];
            addrs[0] = 32'h8; addrs[1] = 32'hC; addrs[2] = 32'h40; addrs[3] = 32'h100;
            set_lane(1, $urandom_range(0, 2), addrs[$urandom_range(0, 3)], $urandom);
            set_lane(2, $urandom_range(0, 2), addrs[$urandom_range(0, 3)], $urandom);
            run_bundle("rand", ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
